// File: rtl/shared_mul_gf2n_hs.sv
// DOM-indep masked multiplier over GF(2^N), any share count.
// Cross terms are refreshed and registered before compression.
module shared_mul_gf2n_hs #(
  parameter int         N      = 2,
  parameter logic [N:0] POLY   = 3'b111,
  parameter int         SHARES = 2,
  parameter int         OUTREG = 0
) (
  input  logic                            ClkxCI,
  input  logic                            RstxBI,
  input  logic [N*SHARES-1:0]             _XxDI,
  input  logic [N*SHARES-1:0]             _YxDI,
  input  logic [N*SHARES*(SHARES-1)/2-1:0] _ZxDI,
  input  logic                            InValidxSI,
  output logic                            InReadyxSO,
  output logic [N*SHARES-1:0]             _QxDO,
  output logic                            OutValidxSO,
  input  logic                            OutReadyxSI
);

  function automatic logic [N-1:0] gf_mul(
    input logic [N-1:0] a,
    input logic [N-1:0] b
  );
    logic [N-1:0] r;
    logic [N-1:0] t;
    r = '0;
    t = a;
    for (int k = 0; k < N; k++) begin
      if (b[k]) r = r ^ t;
      t = t[N-1] ? ((t << 1) ^ POLY[N-1:0]) : (t << 1);
    end
    return r;
  endfunction

  function automatic int pidx(input int i, input int j);
    int a;
    int b;
    a = (i < j) ? i : j;
    b = (i < j) ? j : i;
    return a + b * (b - 1) / 2;
  endfunction

  logic [N-1:0]        r_ff  [SHARES][SHARES];
  logic [N-1:0]        w_nxt [SHARES][SHARES];
  logic [N*SHARES-1:0] w_cmp;
  logic                r_v1;
  logic                w_acc;
  logic                w_cons;

  always_comb begin
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        w_nxt[i][j] = gf_mul(_XxDI[i*N +: N], _YxDI[j*N +: N]);
        if (i != j)
          w_nxt[i][j] = w_nxt[i][j] ^ _ZxDI[pidx(i, j)*N +: N];
      end
    end
  end

  // Compression sees registered terms only
  always_comb begin
    w_cmp = '0;
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        w_cmp[i*N +: N] = w_cmp[i*N +: N] ^ r_ff[i][j];
      end
    end
  end

  assign InReadyxSO = ~r_v1 | w_cons;
  assign w_acc      = InValidxSI & InReadyxSO;

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      r_v1 <= 1'b0;
      for (int i = 0; i < SHARES; i++) begin
        for (int j = 0; j < SHARES; j++) begin
          r_ff[i][j] <= '0;
        end
      end
    end else begin
      r_v1 <= w_acc | (r_v1 & ~w_cons);
      if (w_acc) r_ff <= w_nxt;
    end
  end

  if (OUTREG != 0) begin : g_oreg
    logic [N*SHARES-1:0] r_qr;
    logic                r_v2;
    logic                w_adv2;

    assign w_adv2 = r_v1 & (~r_v2 | OutReadyxSI);

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
        r_qr <= '0;
        r_v2 <= 1'b0;
      end else begin
        r_v2 <= w_adv2 | (r_v2 & ~OutReadyxSI);
        if (w_adv2) r_qr <= w_cmp;
      end
    end

    assign _QxDO       = r_qr;
    assign OutValidxSO = r_v2;
    assign w_cons      = w_adv2;
  end else begin : g_comb
    assign _QxDO       = w_cmp;
    assign OutValidxSO = r_v1;
    assign w_cons      = OutReadyxSI;
  end

endmodule

// File: tb/tb_shared_mul_gf2n_hs.sv
// Bench for shared_mul_gf2n_hs: GF(4)/2-share comb output and
// GF(256)/3-share registered output, scoreboard on both.
module tb_shared_mul_gf2n_hs;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  x0, y0, q0;
  logic [1:0]  z0;
  logic        iv0, ir0, ov0, or0;
  logic [23:0] x1, y1, z1, q1;
  logic        iv1, ir1, ov1, or1;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] sb0[$];
  logic [7:0] sb1[$];

  shared_mul_gf2n_hs #(
    .N(2), .POLY(3'b111), .SHARES(2), .OUTREG(0)
  ) dut0 (
    .ClkxCI(clk), .RstxBI(rst_n),
    ._XxDI(x0), ._YxDI(y0), ._ZxDI(z0),
    .InValidxSI(iv0), .InReadyxSO(ir0),
    ._QxDO(q0), .OutValidxSO(ov0), .OutReadyxSI(or0)
  );

  shared_mul_gf2n_hs #(
    .N(8), .POLY(9'h11B), .SHARES(3), .OUTREG(1)
  ) dut1 (
    .ClkxCI(clk), .RstxBI(rst_n),
    ._XxDI(x1), ._YxDI(y1), ._ZxDI(z1),
    .InValidxSI(iv1), .InReadyxSO(ir1),
    ._QxDO(q1), .OutValidxSO(ov1), .OutReadyxSI(or1)
  );

  // Schoolbook carry-less product, then reduce from the top
  function automatic int gfm(input int a, input int b, input int n, input int poly);
    int r;
    r = 0;
    for (int i = 0; i < n; i++) if (b[i]) r = r ^ (a << i);
    for (int k = 2*n-2; k >= n; k--) if (r[k]) r = r ^ (poly << (k - n));
    return r;
  endfunction

  function automatic logic [3:0] ref0(input logic [3:0] x, input logic [3:0] y, input logic [1:0] z);
    int a0, a1, b0, b1, q0i, q1i;
    a0 = int'(x[1:0]); a1 = int'(x[3:2]);
    b0 = int'(y[1:0]); b1 = int'(y[3:2]);
    q0i = gfm(a0, b0, 2, 7) ^ gfm(a0, b1, 2, 7) ^ int'(z);
    q1i = gfm(a1, b1, 2, 7) ^ gfm(a1, b0, 2, 7) ^ int'(z);
    return {q1i[1:0], q0i[1:0]};
  endfunction

  function automatic logic [7:0] xr3(input logic [23:0] v);
    return v[7:0] ^ v[15:8] ^ v[23:16];
  endfunction

  function automatic logic [7:0] unm1(input logic [23:0] x, input logic [23:0] y);
    int r;
    r = gfm(int'(xr3(x)), int'(xr3(y)), 8, 'h11B);
    return r[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc1(input bit rnd);
    bit a;
    int t;
    t = 0;
    do begin
      if (rnd) or1 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      a = ir1;
      @(posedge clk);
      #1;
      t++;
      if (!a && t > 100) begin
        n_cmp++;
        n_err++;
        $display("FAIL acc1_timeout observed=stalled required=accept");
        a = 1'b1;
      end
    end while (!a);
    iv1 = 1'b0;
  endtask

  task automatic send1(input logic [23:0] x, input logic [23:0] y, input logic [23:0] z);
    x1 = x; y1 = y; z1 = z; iv1 = 1'b1;
    wait_acc1(1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ov0 && or0) begin
        n_cmp++;
        assert (sb0.size() > 0) else begin
          n_err++;
          $error("FAIL sb0_underflow observed=output expected=none");
        end
        if (sb0.size() > 0) chk("dut0_q", 32'(q0), 32'(sb0.pop_front()));
      end
      if (iv0 && ir0) sb0.push_back(ref0(x0, y0, z0));
      if (ov1 && or1) begin
        n_cmp++;
        assert (sb1.size() > 0) else begin
          n_err++;
          $error("FAIL sb1_underflow observed=output expected=none");
        end
        if (sb1.size() > 0) chk("dut1_xor", 32'(xr3(q1)), 32'(sb1.pop_front()));
      end
      if (iv1 && ir1) sb1.push_back(unm1(x1, y1));
    end
  end

  initial begin
    logic [3:0] e0;
    logic [7:0] ea, r1, r2, s1, s2;
    int t;
    x0 = '0; y0 = '0; z0 = '0; iv0 = 1'b0; or0 = 1'b1;
    x1 = '0; y1 = '0; z1 = '0; iv1 = 1'b0; or1 = 1'b1;
    #2;
    chk("rst_ov0", 32'(ov0), 0);
    chk("rst_ir0", 32'(ir0), 1);
    chk("rst_q0", 32'(q0), 0);
    chk("rst_ov1", 32'(ov1), 0);
    chk("rst_ir1", 32'(ir1), 1);
    chk("rst_q1", 32'(q1), 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // X=(1,3) Y=(2,1) Z=2 -> Q=(1,0)
    x0 = {2'd3, 2'd1}; y0 = {2'd1, 2'd2}; z0 = 2'd2; iv0 = 1'b1;
    step();
    iv0 = 1'b0;
    chk("t1_q", 32'(q0), 32'h1);
    chk("t1_v", 32'(ov0), 1);
    chk("t1_xor", 32'(q0[1:0] ^ q0[3:2]), 1);

    // Same operands, Z=0 then Z=1, back to back
    x0 = {2'd0, 2'd2}; y0 = {2'd0, 2'd3}; z0 = 2'd0; iv0 = 1'b1;
    step();
    chk("z0_q", 32'(q0), 32'h1);
    z0 = 2'd1;
    step();
    iv0 = 1'b0;
    chk("z1_q", 32'(q0), 32'h4);
    chk("z1_v", 32'(ov0), 1);
    step();

    // Stall with toggling inputs: held result must not move
    x0 = 4'hB; y0 = 4'h6; z0 = 2'd3; or0 = 1'b0; iv0 = 1'b1;
    e0 = ref0(4'hB, 4'h6, 2'd3);
    step();
    for (int i = 0; i < 5; i++) begin
      z0 = 2'($urandom);
      x0 = 4'($urandom);
      chk("stall_q", 32'(q0), 32'(e0));
      chk("stall_ir", 32'(ir0), 0);
      chk("stall_v", 32'(ov0), 1);
      step();
    end
    iv0 = 1'b0; or0 = 1'b1;
    step(); step();

    // 0x53 * 0xCA = 0x01 in GF(256)
    r1 = 8'($urandom); r2 = 8'($urandom);
    s1 = 8'($urandom); s2 = 8'($urandom);
    send1({r2, r1, 8'h53 ^ r1 ^ r2}, {s2, s1, 8'hCA ^ s1 ^ s2}, 24'($urandom));
    chk("ex_v_lat1", 32'(ov1), 0);
    step();
    chk("ex_v", 32'(ov1), 1);
    chk("ex_xor", 32'(xr3(q1)), 32'h01);
    step(); step();

    // Backpressure on registered output
    or1 = 1'b0;
    ea = unm1(24'h123456, 24'h89ABCD);
    send1(24'h123456, 24'h89ABCD, 24'h0F0F0F);
    send1(24'h777777, 24'h010203, 24'h55AA55);
    chk("bp_ir", 32'(ir1), 0);
    chk("bp_v", 32'(ov1), 1);
    chk("bp_q", 32'(xr3(q1)), 32'(ea));
    x1 = 24'hC0FFEE; y1 = 24'hBADA55; z1 = 24'h13579B; iv1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_ir", 32'(ir1), 0);
      chk("bp_hold_q", 32'(xr3(q1)), 32'(ea));
    end
    or1 = 1'b1;
    wait_acc1(1'b0);
    send1(24'hFEDCBA, 24'h246801, 24'h99AABB);

    // Random regression with random output stalls
    for (int k = 0; k < 150; k++) begin
      x1 = 24'($urandom); y1 = 24'($urandom); z1 = 24'($urandom);
      iv1 = 1'b1;
      wait_acc1(1'b1);
      if ($urandom_range(0, 3) == 0) step();
    end
    or1 = 1'b1;
    t = 0;
    while ((sb1.size() != 0 || sb0.size() != 0) && t < 20) begin
      step();
      t++;
    end
    chk("sb1_drained", 32'(sb1.size()), 0);
    chk("sb0_drained", 32'(sb0.size()), 0);

    // Async reset between edges with a held result
    x0 = 4'h7; y0 = 4'hD; z0 = 2'd1; or0 = 1'b0; iv0 = 1'b1;
    step();
    iv0 = 1'b0;
    chk("pre_rst_v", 32'(ov0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ov0", 32'(ov0), 0);
    chk("arst_q0", 32'(q0), 0);
    chk("arst_ir0", 32'(ir0), 1);
    chk("arst_ov1", 32'(ov1), 0);
    sb0.delete();
    sb1.delete();
    step();
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
